// File: rtl/fir_decim_pkg.sv
// Shared globals for the FM audio decimating FIR: sample width,
// quantisation shift, coefficient set and the FIR state encoding.
package fir_decim_pkg;

   localparam int DATA_SIZE    = 32;
   localparam int QUANT_BITS   = 10;
   localparam int NUM_TAPS_DEF = 32;
   localparam int DECIM_DEF    = 8;

   typedef logic signed [DATA_SIZE-1:0] sample_t;

   // Q10 coefficients; deliberately asymmetric so tap ordering
   // mistakes change the output.
   localparam sample_t FIR_COEFFS [0:NUM_TAPS_DEF-1] = '{
      -3,   -17,  -29,  -31,  -11,  36,   104,  177,
      231,  238,  178,  48,   -130, -312, -441, -463,
      1200, 2048, 1601, 900,  411,  97,   -58,  -120,
      -133, -112, -76,  -41,  -15,  2,    9,    6
   };

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_MAC   = 2'd1,
      S_WRITE = 2'd2
   } state_types;

endpackage

// File: rtl/fir_decim.sv
// Decimating FIR: pops DECIMATION samples from the input FIFO, runs one
// serial MAC pass over NUM_TAPS taps, then pushes one result.
// Ports: clock/reset (async, active-high); x_in_dout/x_in_empty/
// x_in_rd_en = input FIFO (FWFT); y_out_din/y_out_full/y_out_wr_en =
// output FIFO.
module fir_decim
   import fir_decim_pkg::*;
#(
   parameter int      NUM_TAPS   = NUM_TAPS_DEF,
   parameter int      DECIMATION = DECIM_DEF,
   parameter sample_t COEFFS [0:NUM_TAPS-1] = FIR_COEFFS
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic signed [DATA_SIZE-1:0] x_in_dout,
   input  logic                        x_in_empty,
   output logic                        x_in_rd_en,
   output logic                        y_out_wr_en,
   input  logic                        y_out_full,
   output logic signed [DATA_SIZE-1:0] y_out_din
);

   localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam int LW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
   localparam logic [TW-1:0] LAST_TAP  = TW'(NUM_TAPS - 1);
   localparam logic [LW-1:0] LAST_LOAD = LW'(DECIMATION - 1);

   state_types     state_q, state_d;
   sample_t        hist_q [0:NUM_TAPS-1];
   logic [LW-1:0]  load_cnt_q, load_cnt_d;
   logic [TW-1:0]  tap_cnt_q, tap_cnt_d;
   sample_t        acc_q, acc_d;
   logic           shift_en;

   logic signed [2*DATA_SIZE-1:0] prod;
   sample_t                       term;

   // Full-width signed product, rescaled, then wrapped to sample width.
   assign prod = COEFFS[tap_cnt_q] * hist_q[tap_cnt_q];
   assign term = DATA_SIZE'(prod >>> QUANT_BITS);

   always_comb begin
      state_d     = state_q;
      load_cnt_d  = load_cnt_q;
      tap_cnt_d   = tap_cnt_q;
      acc_d       = acc_q;
      shift_en    = 1'b0;
      x_in_rd_en  = 1'b0;
      y_out_wr_en = 1'b0;
      y_out_din   = '0;
      unique case (state_q)
         S_LOAD: begin
            if (!x_in_empty && !reset) begin
               x_in_rd_en = 1'b1;
               shift_en   = 1'b1;
               if (load_cnt_q == LAST_LOAD) begin
                  load_cnt_d = '0;
                  acc_d      = '0;
                  tap_cnt_d  = '0;
                  state_d    = S_MAC;
               end else begin
                  load_cnt_d = load_cnt_q + LW'(1);
               end
            end
         end
         S_MAC: begin
            acc_d = acc_q + term;
            if (tap_cnt_q == LAST_TAP) begin
               tap_cnt_d = '0;
               state_d   = S_WRITE;
            end else begin
               tap_cnt_d = tap_cnt_q + TW'(1);
            end
         end
         S_WRITE: begin
            if (!y_out_full && !reset) begin
               y_out_wr_en = 1'b1;
               y_out_din   = acc_q;
               state_d     = S_LOAD;
            end
         end
         default: begin
            state_d = S_LOAD;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_LOAD;
         load_cnt_q <= '0;
         tap_cnt_q  <= '0;
         acc_q      <= '0;
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         tap_cnt_q  <= tap_cnt_d;
         acc_q      <= acc_d;
      end
   end

   // x[0] is always the newest sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            hist_q[i] <= '0;
         end
      end else if (shift_en) begin
         hist_q[0] <= x_in_dout;
         for (int i = 1; i < NUM_TAPS; i++) begin
            hist_q[i] <= hist_q[i-1];
         end
      end
   end

endmodule

// File: tb/tb_fir_decim.sv
// Scoreboard bench for fir_decim: FIFO-model driver, stream-level
// golden model, and a monitor that checks every output-FIFO push.
module tb_fir_decim;
   import fir_decim_pkg::*;

   localparam int NT = NUM_TAPS_DEF;
   localparam int D  = DECIM_DEF;

   logic                        clock = 1'b0;
   logic                        reset = 1'b1;
   logic signed [DATA_SIZE-1:0] x_in_dout = '0;
   logic                        x_in_empty = 1'b1;
   logic                        x_in_rd_en;
   logic                        y_out_wr_en;
   logic                        y_out_full = 1'b0;
   logic signed [DATA_SIZE-1:0] y_out_din;

   fir_decim dut (
      .clock      (clock),
      .reset      (reset),
      .x_in_dout  (x_in_dout),
      .x_in_empty (x_in_empty),
      .x_in_rd_en (x_in_rd_en),
      .y_out_wr_en(y_out_wr_en),
      .y_out_full (y_out_full),
      .y_out_din  (y_out_din)
   );

   always #5 clock = ~clock;

   int  in_q  [$];
   int  mdl_s [$];
   int  exp_q [$];
   int  ntests = 0;
   int  nfail  = 0;
   int  rd_cnt = 0;
   int  wr_cnt = 0;
   bit  rd_fire = 1'b0;
   bit  phase = 1'b0;
   int  bubble_mode = 0;
   bit  full_force = 1'b0;
   bit  full_rand = 1'b0;

   task automatic check(input bit ok, input string name,
                        input longint act, input longint req);
      ntests++;
      if (!ok) begin
         nfail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Output k from the stream definition: per-tap product rescaled and
   // wrapped to the sample width, summed with wrap-around.
   function automatic int model_out(int k);
      int     acc;
      longint p;
      int     n;
      int     x;
      acc = 0;
      for (int i = 0; i < NT; i++) begin
         n = k * D - 1 - i;
         x = (n >= 0) ? mdl_s[n] : 0;
         p = longint'(FIR_COEFFS[i]) * longint'(x);
         acc = acc + int'(p >>> QUANT_BITS);
      end
      return acc;
   endfunction

   task automatic feed(input int s);
      in_q.push_back(s);
      mdl_s.push_back(s);
      if ((mdl_s.size() % D) == 0) begin
         exp_q.push_back(model_out(mdl_s.size() / D));
      end
   endtask

   // Input/output FIFO model, updated away from the active edge.
   always @(negedge clock) begin
      int tmp;
      bit bub;
      if (rd_fire && in_q.size() != 0) begin
         tmp = in_q.pop_front();
      end
      phase = ~phase;
      bub = 1'b0;
      if (bubble_mode == 1) bub = phase;
      if (bubble_mode == 2) bub = 1'($urandom_range(0, 1));
      x_in_empty = (in_q.size() == 0) || bub;
      x_in_dout  = (in_q.size() != 0) ? in_q[0] : 0;
      y_out_full = full_force || (full_rand && $urandom_range(0, 2) == 0);
      #1;
      rd_fire = x_in_rd_en && !x_in_empty && !reset;
   end

   // Monitor: protocol rules every cycle, data against scoreboard.
   initial begin
      int e;
      forever begin
         @(negedge clock);
         #2;
         if (reset) begin
            check(!x_in_rd_en && !y_out_wr_en && y_out_din == 0,
                  "reset_outputs", {x_in_rd_en, y_out_wr_en}, 0);
         end else begin
            check(!(x_in_rd_en && x_in_empty), "rd_when_empty",
                  x_in_rd_en, 0);
            check(!(x_in_rd_en && y_out_wr_en), "rd_and_wr",
                  {x_in_rd_en, y_out_wr_en}, 0);
            check(!(y_out_wr_en && y_out_full), "wr_when_full",
                  y_out_wr_en, 0);
            check(y_out_wr_en || y_out_din == 0, "din_idle",
                  longint'(y_out_din), 0);
            if (x_in_rd_en) rd_cnt++;
            if (y_out_wr_en) begin
               wr_cnt++;
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_write",
                        longint'(y_out_din), 0);
               end else begin
                  e = exp_q.pop_front();
                  check(y_out_din == e, "y_out",
                        longint'(y_out_din), longint'(e));
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clock);
      #3;
      reset = 1'b1;
      rd_fire = 1'b0;
      in_q.delete();
      exp_q.delete();
      mdl_s.delete();
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_q.size() != 0) && n < budget) begin
         @(posedge clock);
         n++;
      end
      check(n < budget, {name, "_drain"}, exp_q.size(), 0);
      repeat (5) @(posedge clock);
   endtask

   task automatic impulse(input int amp);
      feed(amp);
      for (int i = 0; i < 63; i++) feed(0);
   endtask

   initial begin
      int w0;
      int r0;
      int n;

      do_reset();
      check(wr_cnt == 0 && rd_cnt == 0, "post_reset_idle", wr_cnt, 0);

      // Impulse
      w0 = wr_cnt;
      impulse(1024);
      drain(2000, "impulse");
      check(wr_cnt - w0 == 8, "impulse_count", wr_cnt - w0, 8);

      // DC
      do_reset();
      w0 = wr_cnt;
      for (int i = 0; i < 64; i++) feed(1024);
      drain(2000, "dc");
      check(wr_cnt - w0 == 8, "dc_count", wr_cnt - w0, 8);

      // Negative impulse
      do_reset();
      w0 = wr_cnt;
      impulse(-1024);
      drain(2000, "neg_impulse");
      check(wr_cnt - w0 == 8, "neg_count", wr_cnt - w0, 8);

      // Backpressure held in S_WRITE
      do_reset();
      full_force = 1'b1;
      w0 = wr_cnt;
      for (int i = 0; i < 16; i++) feed($urandom_range(0, 8191) - 4096);
      repeat (50) @(posedge clock);
      r0 = rd_cnt;
      repeat (20) @(posedge clock);
      check(rd_cnt == r0, "bp_no_reads", rd_cnt - r0, 0);
      check(wr_cnt == w0, "bp_no_writes", wr_cnt - w0, 0);
      full_force = 1'b0;
      repeat (3) @(posedge clock);
      check(wr_cnt - w0 == 1, "bp_one_write", wr_cnt - w0, 1);
      drain(2000, "bp");
      check(wr_cnt - w0 == 2, "bp_count", wr_cnt - w0, 2);

      // Empty bubbles
      do_reset();
      bubble_mode = 1;
      w0 = wr_cnt;
      impulse(1024);
      drain(4000, "bubbles");
      check(wr_cnt - w0 == 8, "bubbles_count", wr_cnt - w0, 8);
      bubble_mode = 0;

      // Reset in the middle of the second MAC pass
      do_reset();
      w0 = wr_cnt;
      for (int i = 0; i < 16; i++) feed($urandom_range(1, 4096));
      n = 0;
      while (wr_cnt == w0 && n < 200) begin
         @(posedge clock);
         n++;
      end
      check(n < 200, "mid_first_write", n, 0);
      repeat (18) @(posedge clock);
      #3;
      reset = 1'b1;
      rd_fire = 1'b0;
      in_q.delete();
      exp_q.delete();
      mdl_s.delete();
      w0 = wr_cnt;
      for (int i = 0; i < 8; i++) feed(1024);
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b0;
      drain(2000, "mid_reset");
      check(wr_cnt - w0 == 1, "mid_reset_count", wr_cnt - w0, 1);

      // Random samples with random bubbles and backpressure
      do_reset();
      bubble_mode = 2;
      full_rand = 1'b1;
      w0 = wr_cnt;
      for (int i = 0; i < 240; i++) begin
         if (i % 3 == 0) feed(int'($urandom));
         else feed($urandom_range(0, 65535) - 32768);
      end
      drain(20000, "random");
      check(wr_cnt - w0 == 30, "random_count", wr_cnt - w0, 30);
      bubble_mode = 0;
      full_rand = 1'b0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
